// File: rtl/zc_spi_pkg.sv
// Shared types and constants for the Z-Controller SPI master.
// Port addresses are the CPU I/O ports the host bus decodes onto cfg_wr/data_wr.
package zc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam logic [7:0] ZC_CFG   = 8'h77;
  localparam logic [7:0] ZC_DATA  = 8'h57;

  localparam logic [7:0] RST_DOUT = 8'hFF;
  localparam logic       RST_CS_N = 1'b1;
  localparam logic       RST_MOSI = 1'b1;
  localparam logic [7:0] AUTO_TX  = 8'hFF;

endpackage

// File: rtl/zc_spi_if.sv
// CPU register strobes plus the four SPI pins of the Z-Controller master.
// The master modport is the controller side; slave is the CPU/card side.
interface zc_spi_if;

  logic       cfg_wr;
  logic       data_wr;
  logic       data_rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  cfg_wr, data_wr, data_rd, din, spi_miso,
    output dout, busy, spi_cs_n, spi_sck, spi_mosi
  );

  modport slave (
    output cfg_wr, data_wr, data_rd, din, spi_miso,
    input  dout, busy, spi_cs_n, spi_sck, spi_mosi
  );

endinterface

// File: rtl/zc_spi_tick.sv
// ce-gated SCK half-period divider: o_tick marks the last ce of each half-period.
// Held at zero while i_clear is high so every exchange starts on a fresh half-period.
module zc_spi_tick #(
  parameter int unsigned CLKDIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ce,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(CLKDIV - 1);

  logic [7:0] r_div;

  assign o_tick = i_ce & ~i_clear & (r_div == LAST);

  // NOTE: the reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_div <= '0;
    end else if (i_ce) begin
      r_div <= (r_div == LAST) ? 8'd0 : r_div + 8'd1;
    end
  end

endmodule

// File: rtl/zc_spi_master.sv
// Z-Controller-compatible SPI master, mode 0, 8-bit frames, MSB first.
// Two-process FSM; timing comes from zc_spi_tick, shifting and bit count live here.
module zc_spi_master
  import zc_spi_pkg::*;
#(
  parameter int unsigned CLKDIV  = 1,
  parameter bit          AUTO_RD = 1'b1
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_ce,
  zc_spi_if.master bus
);

  state_e     r_state, w_state_nx;
  logic [7:0] r_tx,    w_tx_nx;
  logic [7:0] r_rx,    w_rx_nx;
  logic [7:0] r_dout,  w_dout_nx;
  logic [2:0] r_bit,   w_bit_nx;
  logic       r_busy,  w_busy_nx;
  logic       r_sck,   w_sck_nx;
  logic       r_mosi,  w_mosi_nx;
  logic       r_cs_n,  w_cs_n_nx;
  logic       w_tick;
  logic       w_clear;

  assign w_clear = (r_state == IDLE);

  zc_spi_tick #(.CLKDIV(CLKDIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // NOTE: every next-value gets its hold default first, so no path through this block can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = r_tx;
    w_rx_nx    = r_rx;
    w_dout_nx  = r_dout;
    w_bit_nx   = r_bit;
    w_busy_nx  = r_busy;
    w_sck_nx   = r_sck;
    w_mosi_nx  = r_mosi;
    w_cs_n_nx  = r_cs_n;

    // Chip select is independent of the exchange and never aborts it.
    if (bus.cfg_wr) w_cs_n_nx = bus.din[0];

    case (r_state)
      IDLE: begin
        // Start is not gated by ce; a write wins over an auto-start read.
        if (bus.data_wr || (AUTO_RD && bus.data_rd)) begin
          w_tx_nx    = bus.data_wr ? bus.din : AUTO_TX;
          w_mosi_nx  = w_tx_nx[7];
          w_busy_nx  = 1'b1;
          w_bit_nx   = 3'd0;
          w_state_nx = LOW;
        end
      end
      LOW: begin
        if (w_tick) begin
          w_sck_nx   = 1'b1;
          w_rx_nx    = {r_rx[6:0], bus.spi_miso};
          w_state_nx = HIGH;
        end
      end
      HIGH: begin
        if (w_tick) begin
          w_sck_nx = 1'b0;
          if (r_bit == 3'd7) begin
            w_dout_nx  = r_rx;
            w_busy_nx  = 1'b0;
            w_state_nx = IDLE;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_mosi_nx  = r_tx[3'd6 - r_bit];
            w_state_nx = LOW;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= RST_DOUT;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= RST_MOSI;
      r_cs_n  <= RST_CS_N;
    end else begin
      r_state <= w_state_nx;
      r_tx    <= w_tx_nx;
      r_rx    <= w_rx_nx;
      r_dout  <= w_dout_nx;
      r_bit   <= w_bit_nx;
      r_busy  <= w_busy_nx;
      r_sck   <= w_sck_nx;
      r_mosi  <= w_mosi_nx;
      r_cs_n  <= w_cs_n_nx;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.busy     = r_busy;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.spi_sck  = r_sck;
  assign bus.spi_mosi = r_mosi;

endmodule

// File: tb/tb_zc_spi_master.sv
// Self-checking bench for zc_spi_master: two instances (CLKDIV=1 and CLKDIV=3) driven
// through one set of strobes, checked against a byte-level model of the SPI exchange.
module tb_zc_spi_master;
  import zc_spi_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  always #5 clk = ~clk;

  zc_spi_if bus1();
  zc_spi_if bus3();

  bit         sel;  // 0 selects the CLKDIV=1 instance, 1 the CLKDIV=3 instance
  logic       t_cfg_wr, t_data_wr, t_data_rd, t_miso;
  logic [7:0] t_din;

  assign bus1.cfg_wr   = t_cfg_wr  & ~sel;
  assign bus1.data_wr  = t_data_wr & ~sel;
  assign bus1.data_rd  = t_data_rd & ~sel;
  assign bus1.din      = t_din;
  assign bus1.spi_miso = t_miso;
  assign bus3.cfg_wr   = t_cfg_wr  & sel;
  assign bus3.data_wr  = t_data_wr & sel;
  assign bus3.data_rd  = t_data_rd & sel;
  assign bus3.din      = t_din;
  assign bus3.spi_miso = t_miso;

  logic       o_sck, o_mosi, o_cs_n, o_busy;
  logic [7:0] o_dout;
  assign o_sck  = sel ? bus3.spi_sck  : bus1.spi_sck;
  assign o_mosi = sel ? bus3.spi_mosi : bus1.spi_mosi;
  assign o_cs_n = sel ? bus3.spi_cs_n : bus1.spi_cs_n;
  assign o_busy = sel ? bus3.busy     : bus1.busy;
  assign o_dout = sel ? bus3.dout     : bus1.dout;

  zc_spi_master #(.CLKDIV(1), .AUTO_RD(1'b1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .bus(bus1));
  zc_spi_master #(.CLKDIV(3), .AUTO_RD(1'b1)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .bus(bus3));

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] model_dout [2];
  logic       model_cs   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Host port write: one-clk strobe decoded from the Z-Controller port address.
  task automatic cpu_out(input logic [7:0] addr, input logic [7:0] data);
    t_din = data;
    if (addr == ZC_CFG)  t_cfg_wr  = 1'b1;
    if (addr == ZC_DATA) t_data_wr = 1'b1;
    tick_clk();
    t_cfg_wr  = 1'b0;
    t_data_wr = 1'b0;
    if (addr == ZC_CFG) model_cs[sel] = data[0];
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/sck"},  o_sck,  0);
    check({tag, "/mosi"}, o_mosi, 1);
    check({tag, "/cs_n"}, o_cs_n, 1);
    check({tag, "/busy"}, o_busy, 0);
    check({tag, "/dout"}, o_dout, 8'hFF);
  endtask

  // One full exchange. The slave drives slv MSB first (or echoes MOSI when loopback);
  // MISO carries garbage while SCK is high so a wrong sampling edge is caught.
  // At cycle inj_cyc a data_wr, data_rd and cfg_wr are all pulsed together.
  task automatic exchange(input string tag, input bit use_rd, input logic [7:0] tx,
                          input bit loopback, input logic [7:0] slv, input int ce_pct,
                          input int inj_cyc, input logic [7:0] inj_din);
    int         div, rises, ticks, last_edge, done_tick;
    bit         bad_half, bad_dout, bad_mosi, prev_sck, prev_mosi, ce_v;
    logic [7:0] exp_tx, exp_rx, mosi_bits;
    div       = sel ? 3 : 1;
    exp_tx    = use_rd ? 8'hFF : tx;
    exp_rx    = loopback ? exp_tx : slv;
    rises     = 0;
    ticks     = 0;
    last_edge = 0;
    done_tick = -1;
    bad_half  = 0;
    bad_dout  = 0;
    bad_mosi  = 0;
    mosi_bits = '0;

    check({tag, "/rd_value"}, o_dout, model_dout[sel]);
    ce = 1'b0;
    if (use_rd) begin
      t_data_rd = 1'b1;
      tick_clk();
      t_data_rd = 1'b0;
    end else begin
      cpu_out(ZC_DATA, tx);
    end
    check({tag, "/busy_rise"}, o_busy, 1);
    check({tag, "/mosi_first"}, o_mosi, exp_tx[7]);
    check({tag, "/dout_at_start"}, o_dout, model_dout[sel]);
    prev_sck  = o_sck;
    prev_mosi = o_mosi;

    for (int cyc = 0; cyc < 2000 && done_tick < 0; cyc++) begin
      if (o_sck == 1'b0) t_miso = loopback ? o_mosi : ((rises < 8) ? slv[3'(7 - rises)] : 1'b0);
      else               t_miso = ~t_miso;
      if (cyc == inj_cyc) begin
        t_data_wr = 1'b1;
        t_data_rd = 1'b1;
        t_cfg_wr  = 1'b1;
        t_din     = inj_din;
        model_cs[sel] = inj_din[0];
      end
      ce_v = ($urandom_range(99) < ce_pct);
      ce   = ce_v;
      tick_clk();
      t_data_wr = 1'b0;
      t_data_rd = 1'b0;
      t_cfg_wr  = 1'b0;
      if (ce_v) ticks++;
      if (o_mosi != prev_mosi && !(prev_sck && !o_sck)) bad_mosi = 1;
      if (o_sck != prev_sck) begin
        if (ticks - last_edge != div) bad_half = 1;
        last_edge = ticks;
        if (o_sck) begin
          rises++;
          mosi_bits = {mosi_bits[6:0], o_mosi};
        end
      end
      prev_sck  = o_sck;
      prev_mosi = o_mosi;
      if (!o_busy) done_tick = ticks;
      else if (o_dout !== model_dout[sel]) bad_dout = 1;
    end
    ce = 1'b1;
    model_dout[sel] = exp_rx;

    check({tag, "/finished"},   (done_tick >= 0), 1);
    check({tag, "/busy_ticks"}, done_tick, 16 * div);
    check({tag, "/pulses"},     rises, 8);
    check({tag, "/mosi_bits"},  mosi_bits, exp_tx);
    check({tag, "/dout"},       o_dout, exp_rx);
    check({tag, "/half_period"}, bad_half, 0);
    check({tag, "/mosi_on_fall"}, bad_mosi, 0);
    check({tag, "/dout_stable"}, bad_dout, 0);
    check({tag, "/mosi_hold"},  o_mosi, exp_tx[0]);
    check({tag, "/sck_idle"},   o_sck, 0);
    check({tag, "/cs_n"},       o_cs_n, model_cs[sel]);
  endtask

  initial begin
    int quiet_bad;
    sel       = 1'b0;
    ce        = 1'b1;
    t_cfg_wr  = 1'b0;
    t_data_wr = 1'b0;
    t_data_rd = 1'b0;
    t_miso    = 1'b0;
    t_din     = '0;
    model_dout[0] = 8'hFF; model_dout[1] = 8'hFF;
    model_cs[0]   = 1'b1;  model_cs[1]   = 1'b1;

    reset = 1'b1;
    repeat (3) tick_clk();
    check_reset_state("reset1");
    sel = 1'b1;
    check_reset_state("reset3");
    sel = 1'b0;
    reset = 1'b0;
    tick_clk();

    // Loopback, full-rate ce: busy lasts exactly 16 clocks.
    exchange("t1_loop_a5", 1'b0, 8'hA5, 1'b1, 8'h00, 100, -1, 8'h00);
    // Slave returns 3C while the master sends 00, ce gaps randomized.
    exchange("t2_slave_3c", 1'b0, 8'h00, 1'b0, 8'h3C, 60, -1, 8'h00);
    // Auto-start read: old byte is returned, FF goes out on MOSI.
    exchange("t3_auto_rd", 1'b1, 8'h00, 1'b0, 8'h96, 75, -1, 8'h00);
    // Second write mid-exchange is ignored; its cfg_wr still drops cs_n.
    exchange("t4_ignore", 1'b0, 8'h12, 1'b0, 8'hE1, 100, 5, 8'h34);
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      if (o_busy !== 1'b0 || o_sck !== 1'b0) quiet_bad++;
    end
    check("t4_no_second_burst", quiet_bad, 0);

    for (int i = 0; i < 6; i++) begin
      exchange($sformatf("rand1_%0d", i), ($urandom_range(3) == 0),
               8'($urandom), ($urandom_range(1) == 1), 8'($urandom),
               $urandom_range(100, 50), -1, 8'h00);
    end

    // Reset while SCK is high in bit 4.
    cpu_out(ZC_CFG, 8'h00);
    check("t5_cs_low", o_cs_n, 0);
    ce = 1'b1;
    t_miso = 1'b1;
    cpu_out(ZC_DATA, 8'hC3);
    repeat (9) tick_clk();
    check("t5_mid_sck", o_sck, 1);
    reset = 1'b1;
    tick_clk();
    check_reset_state("t5_after_reset");
    reset = 1'b0;
    model_dout[0] = 8'hFF;
    model_cs[0]   = 1'b1;
    tick_clk();
    exchange("t5_recover", 1'b0, 8'h5A, 1'b0, 8'h81, 80, -1, 8'h00);

    // CLKDIV=3 instance: chip select toggling, then 48-tick exchanges.
    sel = 1'b1;
    cpu_out(ZC_CFG, 8'h00);
    check("t6_cs_0", o_cs_n, 0);
    cpu_out(ZC_CFG, 8'h01);
    check("t6_cs_1", o_cs_n, 1);
    cpu_out(ZC_CFG, 8'hFE);
    check("t6_cs_bit0_only", o_cs_n, 0);
    exchange("t6_loop_div3", 1'b0, 8'hA5, 1'b1, 8'h00, 100, -1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      exchange($sformatf("rand3_%0d", i), ($urandom_range(3) == 0),
               8'($urandom), ($urandom_range(1) == 1), 8'($urandom),
               $urandom_range(100, 50), -1, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
